// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control for the RV64 core: fetch/decode/execute/mem/writeback for R-type, ld, sd, beq.
// Strobes are registered from the next state; only ir_write/pc_write are gated by mem_ready combinationally.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       ctrl_ALU_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_EXECUTE, S_R_WB, S_BRANCH, S_ERROR
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       pc_write_cond;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           nxt;
  ctrl_t            ctrl_q;
  logic [CW-1:0]    wait_cnt;
  logic [1:0]       fault;
  logic             wait_last;
  logic             retire;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.src_b    = 2'b01;
        c.fetch    = 1'b1;
      end
      S_DECODE:   c.src_b = 2'b10;
      S_MEM_ADDR: begin
        c.src_a = 1'b1;
        c.src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: begin
        c.src_a  = 1'b1;
        c.alu_op = 2'b10;
      end
      S_R_WB:     c.reg_write = 1'b1;
      S_BRANCH: begin
        c.src_a         = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

  assign wait_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt   = state;
    fault = 2'b00;
    case (state)
      S_RESET:    nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          nxt = S_DECODE;
        end else if (wait_last) begin
          nxt   = S_ERROR;
          fault = CODE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: nxt = S_MEM_ADDR;
          OP_R:         nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          default: begin
            nxt   = S_ERROR;
            fault = CODE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: nxt = (opcode == OP_SD) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready) begin
          nxt = S_MEM_WB;
        end else if (wait_last) begin
          nxt   = S_ERROR;
          fault = CODE_TIMEOUT;
        end
      end
      S_MEM_WB:   nxt = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          nxt = S_FETCH;
        end else if (wait_last) begin
          nxt   = S_ERROR;
          fault = CODE_TIMEOUT;
        end
      end
      S_EXECUTE:  nxt = S_R_WB;
      S_R_WB:     nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_ERROR:    nxt = S_ERROR;
      default:    nxt = S_RESET;
    endcase
  end

  // An instruction retires when its last step hands back to FETCH.
  assign retire = (nxt == S_FETCH) &&
                  ((state == S_MEM_WB) || (state == S_MEM_WRITE) ||
                   (state == S_R_WB)   || (state == S_BRANCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      ctrl_q     <= '0;
      wait_cnt   <= '0;
      retired    <= '0;
      error      <= 1'b0;
      error_code <= 2'b00;
    end else begin
      state  <= nxt;
      ctrl_q <= decode_ctrl(nxt);
      if (is_wait(nxt) && (nxt != state)) begin
        wait_cnt <= '0;
      end else if (is_wait(state) && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (retire) begin
        retired <= retired + RET_W'(1);
      end
      // Only the first fault is recorded; ERROR is left only through reset.
      if ((nxt == S_ERROR) && (state != S_ERROR)) begin
        error      <= 1'b1;
        error_code <= fault;
      end
    end
  end

  assign ctrl_ALU_op   = ctrl_q.alu_op;
  assign alu_src_a     = ctrl_q.src_a;
  assign alu_src_b     = ctrl_q.src_b;
  assign iord          = ctrl_q.iord;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign ir_write      = ctrl_q.fetch & mem_ready;
  assign pc_write      = ctrl_q.fetch & mem_ready;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign pc_src        = ctrl_q.pc_src;
  assign reg_write     = ctrl_q.reg_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-recipe reference model checked every cycle, plus directed literal checks.
module tb_multicycle_ctrl_fsm;

  localparam int MEM_TIMEOUT = 16;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int P_RST = 0, P_F = 1, P_D = 2, P_MA = 3, P_MR = 4, P_MWB = 5,
                 P_MW = 6, P_EX = 7, P_RWB = 8, P_BR = 9, P_ERR = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic [1:0]  ctrl_ALU_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord, mem_read, mem_write, ir_write, pc_write;
  logic        pc_write_cond, pc_src, reg_write, mem_to_reg, error;
  logic [1:0]  error_code;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .RET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ctrl_ALU_op(ctrl_ALU_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .error(error), .error_code(error_code), .retired(retired)
  );

  always #5 clk = ~clk;

  // Per-step strobe table: {alu_op[1:0], src_a, src_b[1:0], iord, mem_read, mem_write, fetch, pwc, pc_src, reg_write, mem_to_reg}
  logic [12:0] out_tab [0:10] = '{
    13'b00_0_00_0_0_0_0_0_0_0_0,  // reset
    13'b00_0_01_0_1_0_1_0_0_0_0,  // fetch
    13'b00_0_10_0_0_0_0_0_0_0_0,  // decode
    13'b00_1_10_0_0_0_0_0_0_0_0,  // address calc
    13'b00_0_00_1_1_0_0_0_0_0_0,  // mem read
    13'b00_0_00_0_0_0_0_0_0_1_1,  // load writeback
    13'b00_0_00_1_0_1_0_0_0_0_0,  // mem write
    13'b10_1_00_0_0_0_0_0_0_0_0,  // execute
    13'b00_0_00_0_0_0_0_0_0_1_0,  // R writeback
    13'b01_1_00_0_0_0_0_1_1_0_0,  // branch
    13'b00_0_00_0_0_0_0_0_0_0_0   // error
  };

  int          m_phase = P_RST;
  int          plan[$];
  int          m_wait = 0;
  logic [31:0] m_ret = '0;
  logic [1:0]  m_code = 2'b00;

  function automatic bit is_mem(input int p);
    return (p == P_F) || (p == P_MR) || (p == P_MW);
  endfunction

  task automatic m_advance();
    if (plan.size() > 0) begin
      m_phase = plan.pop_front();
    end else begin
      m_phase = P_F;
      m_ret   = m_ret + 32'd1;
    end
    m_wait = 0;
  endtask

  task automatic m_fault(input logic [1:0] c);
    m_phase = P_ERR;
    m_code  = c;
    plan.delete();
  endtask

  task automatic m_step();
    if (m_phase == P_RST) begin
      m_phase = P_F;
      m_wait  = 0;
    end else if (m_phase == P_ERR) begin
      m_phase = P_ERR;
    end else if (m_phase == P_D) begin
      case (opcode)
        OP_LD:   plan = '{P_MA, P_MR, P_MWB};
        OP_SD:   plan = '{P_MA, P_MW};
        OP_R:    plan = '{P_EX, P_RWB};
        OP_BEQ:  plan = '{P_BR};
        default: m_fault(2'b01);
      endcase
      if (m_phase != P_ERR) m_advance();
    end else if (is_mem(m_phase)) begin
      if (mem_ready) begin
        if (m_phase == P_F) plan.push_back(P_D);
        m_advance();
      end else if (m_wait == MEM_TIMEOUT - 1) begin
        m_fault(2'b10);
      end else begin
        m_wait++;
      end
    end else begin
      m_advance();
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_RST;
      m_wait  = 0;
      m_ret   = '0;
      m_code  = 2'b00;
      plan.delete();
    end else begin
      m_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {ctrl_ALU_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
            pc_write, pc_write_cond, pc_src, reg_write, mem_to_reg, error, error_code};
  endfunction

  // Per-cycle comparison against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [12:0] t;
    logic [16:0] e;
    t = out_tab[m_phase];
    e = {t[12:5], t[4] & mem_ready, t[4] & mem_ready, t[3:0], (m_phase == P_ERR), m_code};
    chk("model_outputs", 32'(dut_vec()), 32'(e));
    chk("model_retired", retired, m_ret);
  end

  task automatic tick(input logic mr, input logic [6:0] op);
    mem_ready = mr;
    opcode    = op;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", 32'(dut_vec()), 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] legal [0:3] = '{OP_LD, OP_SD, OP_R, OP_BEQ};

  initial begin
    int c0;
    int cnt;
    int stall;
    int err_age;
    int r;
    logic [6:0] op;
    logic mr;

    @(posedge clk);
    #1;
    do_reset();

    // R-type from reset: 4 cycles FETCH to FETCH
    tick(1'b1, OP_R);
    chk("r_fetch_mem_read", 32'(mem_read), 32'd1);
    chk("r_fetch_ir_write", 32'(ir_write), 32'd1);
    c0 = cyc;
    tick(1'b1, OP_R);
    tick(1'b1, OP_R);
    chk("r_exec_alu_op", 32'(ctrl_ALU_op), 32'd2);
    chk("r_exec_no_regwr", 32'(reg_write), 32'd0);
    tick(1'b1, OP_R);
    chk("r_wb_reg_write", 32'(reg_write), 32'd1);
    tick(1'b1, OP_R);
    chk("r_latency", 32'(cyc - c0), 32'd4);
    chk("r_retired", retired, 32'd1);

    // ld with three wait cycles in MEM_READ
    c0 = cyc;
    tick(1'b1, OP_LD);
    tick(1'b1, OP_LD);
    tick(1'b0, OP_LD);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_read && iord) cnt++;
      tick(k == 3, OP_LD);
    end
    chk("ld_mem_read_cycles", 32'(cnt), 32'd4);
    chk("ld_wb_strobes", 32'({reg_write, mem_to_reg}), 32'd3);
    tick(1'b1, OP_LD);
    chk("ld_latency", 32'(cyc - c0), 32'd8);
    chk("ld_retired", retired, 32'd2);

    // sd then beq back-to-back
    c0 = cyc;
    tick(1'b1, OP_SD);
    tick(1'b1, OP_SD);
    tick(1'b1, OP_SD);
    chk("sd_mem_write", 32'(mem_write), 32'd1);
    tick(1'b1, OP_SD);
    chk("sd_write_one_cycle", 32'(mem_write), 32'd0);
    tick(1'b1, OP_BEQ);
    tick(1'b1, OP_BEQ);
    chk("beq_strobes", 32'({ctrl_ALU_op, pc_write_cond, pc_src}), 32'b0111);
    tick(1'b1, OP_BEQ);
    chk("sd_beq_latency", 32'(cyc - c0), 32'd7);
    chk("sd_beq_retired", retired, 32'd4);

    // illegal opcode
    tick(1'b1, 7'b1111111);
    tick(1'b1, 7'b1111111);
    chk("illegal_error", 32'({error, error_code}), 32'b101);
    for (int k = 0; k < 20; k++) tick(1'($urandom), 7'($urandom));
    chk("illegal_hold", 32'({error, error_code, mem_read, ir_write}), 32'b10100);
    do_reset();

    // fetch timeout after exactly MEM_TIMEOUT cycles
    tick(1'b0, OP_R);
    for (int k = 0; k < MEM_TIMEOUT - 1; k++) tick(1'b0, OP_R);
    chk("to_still_fetch", 32'({error, mem_read}), 32'b01);
    tick(1'b0, OP_R);
    chk("to_error", 32'({error, error_code}), 32'b110);
    do_reset();

    // ready on the last allowed cycle is accepted
    tick(1'b0, OP_R);
    for (int k = 0; k < MEM_TIMEOUT - 1; k++) tick(1'b0, OP_R);
    mem_ready = 1'b1;
    #1;
    chk("to_last_ir_write", 32'(ir_write), 32'd1);
    tick(1'b1, OP_R);
    chk("to_last_decode", 32'({error, alu_src_b}), 32'b010);
    tick(1'b1, OP_R);
    tick(1'b1, OP_R);
    tick(1'b1, OP_SD);
    chk("pre_sd_retired", retired, 32'd1);

    // reset asserted in the middle of a store
    tick(1'b1, OP_SD);
    tick(1'b1, OP_SD);
    tick(1'b0, OP_SD);
    tick(1'b0, OP_SD);
    chk("mw_held", 32'(mem_write), 32'd1);
    do_reset();
    tick(1'b1, OP_R);
    chk("mw_resume_fetch", 32'(mem_read), 32'd1);

    // randomized traffic
    stall = 0;
    err_age = 0;
    for (int i = 0; i < 3000; i++) begin
      op = opcode;
      if (m_phase == P_F) begin
        r = $urandom_range(0, 19);
        if (r < 18) op = legal[$urandom_range(0, 3)];
        else op = 7'($urandom);
      end
      if (stall > 0) begin
        mr = 1'b0;
        stall--;
      end else if ($urandom_range(0, 199) == 0) begin
        stall = $urandom_range(10, 20);
        mr = 1'b0;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
      end
      if (m_phase == P_ERR) err_age++;
      else err_age = 0;
      if (err_age > 3 || $urandom_range(0, 499) == 0) begin
        do_reset();
        err_age = 0;
      end else begin
        tick(mr, op);
      end
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
